// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Alternating grant under contention; an access that never completes is aborted after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              memerr
);

  // state | meaning
  // IDLE  | evaluate grant
  // IACC  | instruction access on the RAM port
  // IRESP | ihit pulse
  // DACC  | data access on the RAM port
  // DRESP | dhit pulse
  typedef enum logic [2:0] {IDLE, IACC, IRESP, DACC, DRESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                d_pend, grant_d, grant_i, in_acc, in_dacc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Under contention the side that did not win last time gets the port.
  assign d_pend  = dREN | dWEN;
  assign grant_d = d_pend & (~iREN | ~last_d_q);
  assign grant_i = iREN & (~d_pend | last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = DACC;
          addr_d   = daddr;
          store_d  = dstore;
          wr_d     = dWEN;
          last_d_d = 1'b1;
          cnt_d    = '0;
          err_d    = 1'b0;
        end else if (grant_i) begin
          state_d  = IACC;
          addr_d   = iaddr;
          store_d  = '0;
          wr_d     = 1'b0;
          last_d_d = 1'b0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end
      end
      IACC, DACC: begin
        cnt_d = cnt_q + 8'd1;
        if (ramready) begin
          rdata_d = wr_q ? '0 : ramload;
          err_d   = 1'b0;
          state_d = (state_q == IACC) ? IRESP : DRESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = (state_q == IACC) ? IRESP : DRESP;
        end
      end
      IRESP, DRESP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops the strobes at once.
  assign in_acc   = (state_q == IACC) | (state_q == DACC);
  assign in_dacc  = (state_q == DACC);
  assign ramREN   = in_acc & ~(in_dacc & wr_q);
  assign ramWEN   = in_dacc & wr_q;
  assign ramaddr  = in_acc ? addr_q : '0;
  assign ramstore = (in_dacc & wr_q) ? store_q : '0;
  assign ihit     = (state_q == IRESP);
  assign dhit     = (state_q == DRESP);
  assign iload    = ihit ? rdata_q : '0;
  assign dload    = dhit ? rdata_q : '0;
  assign memerr   = (ihit | dhit) & err_q;

endmodule
